wb_busif_bridge: RTL and testbench
==================================

# wb_busif_bridge

Wishbone classic slave that converts single CPU transactions into the generic one-clock bus-interface transactions (wen/ren/addr/wdata/strobe in; rdata/error/request_stall out) consumed by the PWM wrapper. It sits directly upstream of the PWM block. It decodes a base-address window, rebases the address, holds the request while the slave stalls, and returns ack or err. A stall watchdog guarantees every cycle terminates.

## Interface
- BASE_ADDR, 32'h3000_0000, first byte address of the slave window
- ADDR_SPAN, 32'h0000_0100, window size in bytes (power of two)
- ADDR_WIDTH, 32, width of rebased address
- DATA_WIDTH, 32, data width
- TIMEOUT, 16, max cycles held in ACCESS before forced error (>=2)
- CLK  in  1  single clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe, write
- wbs_sel_i  in  DATA_WIDTH/8  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  DATA_WIDTH  write data
- wbs_ack_o  out  1  normal termination
- wbs_err_o  out  1  error termination
- wbs_dat_o  out  DATA_WIDTH  read data, valid with ack
- wen, ren  out  1 each  bus request to slave (registered)
- addr  out  ADDR_WIDTH  wbs_adr_i − BASE_ADDR
- wdata  out  DATA_WIDTH  latched write data
- strobe  out  DATA_WIDTH/8  latched byte selects
- rdata  in  DATA_WIDTH  slave read data
- error  in  1  slave error
- request_stall  in  1  slave not ready; request held

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: on cyc&stb, latch adr/dat/sel/we. In window (BASE_ADDR <= adr < BASE_ADDR+ADDR_SPAN) -> ACCESS, drive wen=we or ren=!we next cycle. Out of window -> RESP with err pending; no wen/ren ever asserted.
- ACCESS: wen/ren, addr, wdata and strobe held stable. If request_stall=0, capture rdata (reads only; writes capture 0) and error, -> RESP, drop wen/ren. If request_stall=1, increment watchdog. If the watchdog reaches TIMEOUT-1 with stall still high -> RESP with err.
- RESP: exactly one cycle of wbs_ack_o (captured error=0) or wbs_err_o (error=1, out-of-window, or timeout). Never both. wbs_dat_o = captured data; 0 on write or err. -> IDLE.
- Abort: cyc_i low while in ACCESS -> drop wen/ren, clear watchdog, IDLE next cycle, no ack/err.
- Master holding stb the cycle after RESP counts as a new request.
- Address subtraction is modulo 2^32, truncated to ADDR_WIDTH. The window check uses the full 32 bits.

## Timing
- Reset (async, nRST low): state IDLE. All outputs are 0: ack, err, dat_o, wen, ren, addr, wdata, strobe. Watchdog is 0.
- Request sampled at edge 0:
  - wen/ren high in cycle 1.
  - No stall: ack/err in cycle 2 (2-cycle latency).
  - Stall N cycles (N < TIMEOUT): ack at cycle 2+N.
  - Timeout: wen/ren high in cycles 1..TIMEOUT, err in cycle TIMEOUT+1.
  - Out of window: err in cycle 1.
- wen/ren are high for exactly the cycles the slave sees the request. The slave completes on the first cycle with request_stall=0.
- Back-to-back: next request accepted in the cycle after RESP. Throughput is 1 transaction per 3 cycles.
- Reset mid-ACCESS: wen/ren drop immediately (asynchronously). No response is issued.

## Structure
- Package wb_busif_pkg:
  - state enum (IDLE, ACCESS, RESP);
  - width localparam for the watchdog, $clog2(TIMEOUT).
- One sub-module, busif_stall_timer: clear/enable counter with terminal-count output.
- Everything else is in one FSM module.

## Test plan
- Write 0x3000_0004, data 0x0000_0064, sel 0xF, no stall -> wen=1 in cycle 1 only, addr=0x4, wdata=0x64, strobe=0xF; ack in cycle 2; err=0.
- Read 0x3000_0008, stall held for 3 cycles, rdata=0xDEAD_BEEF -> ren in cycles 1–4; ack in cycle 5; wbs_dat_o=0xDEAD_BEEF.
- Read 0x3000_1000 (out of window) -> no ren; err in cycle 1; wbs_dat_o=0.
- Write with stall stuck high, TIMEOUT=16 -> wen in cycles 1–16; err in cycle 17; then IDLE accepts a new request.
- Slave returns error=1 on write 0x3000_0000 -> err (not ack) in cycle 2.
- cyc_i dropped in cycle 2 of a stalled read -> ren low from cycle 3, no ack/err. Separately: nRST pulsed mid-ACCESS -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/wb_busif_pkg.sv
// Shared types and sizing helpers for the Wishbone-to-bus-interface bridge.
package wb_busif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DFLT = 16;
  localparam int unsigned WDOG_W       = $clog2(TIMEOUT_DFLT);

  // Watchdog counter width for a given timeout; never narrower than one bit.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/busif_stall_timer.sv
// Clear/enable stall counter; tc_c flags the terminal count and freezes counting.
module busif_stall_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc_c) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc_c = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/wb_busif_bridge.sv
// Wishbone classic slave that issues one-clock bus-interface requests to a
// stallable slave, with a watchdog that forces an error on a stuck stall.
module wb_busif_bridge
  import wb_busif_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [31:0] ADDR_SPAN  = 32'h0000_0100,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = TIMEOUT_DFLT
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wen,
  output logic                    ren,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] strobe,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    error,
  input  logic                    request_stall
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned WD_W  = wdog_width(TIMEOUT);

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic                    wen_d, ren_d, ack_d, err_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d, dat_d;
  logic [SEL_W-1:0]        strobe_d;
  logic [31:0]             off_c;
  logic                    in_win_c;
  logic                    tc_c;
  logic                    wd_clr_c;

  // Window check on the full 32-bit address; offset wraps modulo 2^32.
  assign off_c    = wbs_adr_i - BASE_ADDR;
  assign in_win_c = (wbs_adr_i >= BASE_ADDR) && (off_c < ADDR_SPAN);

  // Watchdog only runs while a stalled request stays in ACCESS.
  assign wd_clr_c = (state_q != ACCESS) || (state_d != ACCESS);

  busif_stall_timer #(
    .WIDTH    (WD_W),
    .TERMINAL (TIMEOUT - 1)
  ) u_stall_timer (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (wd_clr_c),
    .en    (request_stall),
    .tc_c  (tc_c)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    wen_d    = wen;
    ren_d    = ren;
    addr_d   = addr;
    wdata_d  = wdata;
    strobe_d = strobe;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_d     = wbs_we_i;
          addr_d   = ADDR_WIDTH'(off_c);
          wdata_d  = wbs_dat_i;
          strobe_d = wbs_sel_i;
          if (in_win_c) begin
            state_d = ACCESS;
            wen_d   = wbs_we_i;
            ren_d   = !wbs_we_i;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        // A master abort wins over completion: no termination is returned.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
        end else if (!request_stall) begin
          state_d = RESP;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          ack_d   = !error;
          err_d   = error;
          dat_d   = (!we_q && !error) ? rdata : '0;
        end else if (tc_c) begin
          state_d = RESP;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      wen       <= 1'b0;
      ren       <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      strobe    <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wen       <= wen_d;
      ren       <= ren_d;
      addr      <= addr_d;
      wdata     <= wdata_d;
      strobe    <= strobe_d;
      wbs_ack_o <= ack_d;
      wbs_err_o <= err_d;
      wbs_dat_o <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_busif_bridge.sv
// Scoreboard bench for wb_busif_bridge: directed Wishbone transactions with
// hand-computed slave-side requests and terminations checked by monitors.
module tb_wb_busif_bridge;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbs_dat_o;
  logic        wen, ren;
  logic [31:0] addr, wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata = '0;
  logic        error = 1'b0;
  logic        request_stall = 1'b0;

  int errors = 0;
  int checks = 0;
  int cnt = 0;
  int stall_cycles = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    int          n;
  } req_t;

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
    int          start;
    int          lat;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  wb_busif_bridge dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_err_o     (wbs_err_o),
    .wbs_dat_o     (wbs_dat_o),
    .wen           (wen),
    .ren           (ren),
    .addr          (addr),
    .wdata         (wdata),
    .strobe        (strobe),
    .rdata         (rdata),
    .error         (error),
    .request_stall (request_stall)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cnt <= cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: stall for stall_cycles request cycles, then complete.
  initial begin
    int seen = 0;
    forever begin
      @(negedge CLK);
      if (wen || ren) begin
        request_stall = (seen < stall_cycles);
        seen++;
      end else begin
        seen = 0;
        request_stall = 1'b0;
      end
    end
  end

  // Slave-side monitor: request fields, stability and length in cycles.
  initial begin
    bit prev = 0;
    int n = 0;
    forever begin
      @(negedge CLK);
      if (wen || ren) begin
        if (req_q.size() == 0) begin
          if (!prev) check("unexpected_request", {wen, ren}, 64'd0);
        end else begin
          check("req_kind", {wen, ren}, {req_q[0].we, !req_q[0].we});
          check("req_addr", addr, req_q[0].addr);
          check("req_strobe", strobe, req_q[0].strobe);
          if (req_q[0].we) check("req_wdata", wdata, req_q[0].wdata);
        end
        n = prev ? n + 1 : 1;
        prev = 1;
      end else begin
        if (prev && req_q.size() != 0) begin
          check("req_cycles", n, req_q[0].n);
          void'(req_q.pop_front());
        end
        prev = 0;
      end
    end
  end

  // Master-side monitor: termination kind, read data and latency.
  initial begin
    resp_t r;
    forever begin
      @(negedge CLK);
      if (wbs_ack_o && wbs_err_o) check("ack_and_err", 64'd1, 64'd0);
      if (wbs_ack_o || wbs_err_o) begin
        if (resp_q.size() == 0) begin
          check("unexpected_response", {wbs_ack_o, wbs_err_o}, 64'd0);
        end else begin
          r = resp_q.pop_front();
          check("resp_err", wbs_err_o, r.is_err);
          check("resp_ack", wbs_ack_o, !r.is_err);
          check("resp_dat", wbs_dat_o, r.dat);
          check("resp_latency", cnt - r.start, r.lat);
        end
      end
    end
  end

  task automatic run_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int stall_n, input logic slv_err,
                         input logic [31:0] rd, input logic in_win, input logic [31:0] exp_addr,
                         input int exp_n, input logic exp_err, input logic [31:0] exp_dat,
                         input int exp_lat);
    req_t  q;
    resp_t r;
    bit    done = 0;
    @(negedge CLK);
    stall_cycles = stall_n;
    error = slv_err;
    rdata = rd;
    wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    if (in_win) begin
      q = '{we: we, addr: exp_addr, wdata: dat, strobe: sel, n: exp_n};
      req_q.push_back(q);
    end
    r = '{is_err: exp_err, dat: exp_dat, start: cnt, lat: exp_lat};
    resp_q.push_back(r);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (wbs_ack_o || wbs_err_o) done = 1;
    end
    if (!done) check("response_timeout", 64'd0, 64'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, wbs_ack_o, 64'd0);
    check({tag, "_err"}, wbs_err_o, 64'd0);
    check({tag, "_dat_o"}, wbs_dat_o, 64'd0);
    check({tag, "_wen"}, wen, 64'd0);
    check({tag, "_ren"}, ren, 64'd0);
    check({tag, "_addr"}, addr, 64'd0);
    check({tag, "_wdata"}, wdata, 64'd0);
    check({tag, "_strobe"}, strobe, 64'd0);
  endtask

  initial begin
    req_t q;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    //       we    adr            dat            sel   stall slverr rdata          win   exp_addr      n   err   exp_dat        lat
    run_req(1'b1, 32'h3000_0004, 32'h0000_0064, 4'hF, 0,    1'b0, 32'h0,         1'b1, 32'h0000_0004, 1,  1'b0, 32'h0,         2);
    run_req(1'b0, 32'h3000_0008, 32'h0,         4'hF, 3,    1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0008, 4,  1'b0, 32'hDEAD_BEEF, 5);
    run_req(1'b0, 32'h3000_1000, 32'h0,         4'hF, 0,    1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,         0,  1'b1, 32'h0,         1);
    run_req(1'b1, 32'h3000_0010, 32'h1111_2222, 4'hF, 1000, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 16, 1'b1, 32'h0,         17);
    run_req(1'b1, 32'h3000_0020, 32'h0000_00A5, 4'h3, 0,    1'b0, 32'h0,         1'b1, 32'h0000_0020, 1,  1'b0, 32'h0,         2);
    run_req(1'b1, 32'h3000_0000, 32'h0000_0077, 4'hF, 0,    1'b1, 32'h0,         1'b1, 32'h0000_0000, 1,  1'b1, 32'h0,         2);
    run_req(1'b0, 32'h3000_00FC, 32'h0,         4'h1, 1,    1'b0, 32'h1234_5678, 1'b1, 32'h0000_00FC, 2,  1'b0, 32'h1234_5678, 3);
    run_req(1'b0, 32'h2FFF_FFFC, 32'h0,         4'hF, 0,    1'b0, 32'h1234_5678, 1'b0, 32'h0,         0,  1'b1, 32'h0,         1);
    run_req(1'b0, 32'h3000_0100, 32'h0,         4'hF, 0,    1'b0, 32'h1234_5678, 1'b0, 32'h0,         0,  1'b1, 32'h0,         1);
    run_req(1'b0, 32'h3000_0030, 32'h0,         4'hF, 2,    1'b1, 32'hCAFE_F00D, 1'b1, 32'h0000_0030, 3,  1'b1, 32'h0,         4);

    // Master abort: cyc drops during cycle 2 of a stalled read.
    @(negedge CLK);
    stall_cycles = 1000; error = 1'b0;
    wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0044; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    q = '{we: 1'b0, addr: 32'h0000_0044, wdata: 32'h0, strobe: 4'hF, n: 2};
    req_q.push_back(q);
    repeat (2) @(negedge CLK);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort_ren_low", ren, 64'd0);
    check("abort_no_pending_req", req_q.size(), 64'd0);

    // Reset pulsed mid-ACCESS: outputs clear without waiting for a clock.
    @(negedge CLK);
    wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0048; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    q = '{we: 1'b0, addr: 32'h0000_0048, wdata: 32'h0, strobe: 4'hF, n: 2};
    req_q.push_back(q);
    repeat (2) @(negedge CLK);
    #1 nRST = 1'b0;
    #1 check_all_zero("midreset");
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    run_req(1'b1, 32'h3000_0080, 32'h0BAD_F00D, 4'hC, 0,    1'b0, 32'h0,         1'b1, 32'h0000_0080, 1,  1'b0, 32'h0,         2);

    repeat (5) @(negedge CLK);
    check("req_queue_drained", req_q.size(), 64'd0);
    check("resp_queue_drained", resp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "global timeout");
  end

endmodule
